// File: rtl/fir_mac_if.sv
// Sample/coefficient/result bundle for the FIR MAC sequencer.
// The master drives samples and coefficient writes; the slave (the filter) returns results.
interface fir_mac_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int COEFF_WIDTH = 8,
  parameter int TAPS        = 4,
  parameter int ACC_WIDTH   = DATA_WIDTH + COEFF_WIDTH + 2
);
  localparam int AW = $clog2(TAPS);

  logic                          s_valid;
  logic                          s_ready;
  logic signed [DATA_WIDTH-1:0]  s_data;
  logic                          coef_we;
  logic [AW-1:0]                 coef_addr;
  logic signed [COEFF_WIDTH-1:0] coef_data;
  logic                          coef_err;
  logic                          y_valid;
  logic signed [ACC_WIDTH-1:0]   y_out;
  logic                          busy;

  modport master (
    output s_valid, s_data, coef_we, coef_addr, coef_data,
    input  s_ready, coef_err, y_valid, y_out, busy
  );

  modport slave (
    input  s_valid, s_data, coef_we, coef_addr, coef_data,
    output s_ready, coef_err, y_valid, y_out, busy
  );
endinterface

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR filter: one shared multiplier, one tap per cycle.
// state  | meaning
// S_IDLE | waiting for a sample, coefficient writes allowed
// S_MAC  | accumulating c[idx]*x[idx], idx = 0..TAPS-1
module fir_mac_sequencer #(
  parameter int DATA_WIDTH  = 8,
  parameter int COEFF_WIDTH = 8,
  parameter int TAPS        = 4,
  parameter int ACC_WIDTH   = DATA_WIDTH + COEFF_WIDTH + 2
) (
  input logic     clk,
  input logic     rst,
  fir_mac_if.slave bus
);
  localparam int AW = $clog2(TAPS);
  localparam int PW = DATA_WIDTH + COEFF_WIDTH;

  typedef enum logic {S_IDLE, S_MAC} state_t;

  state_t                        state_q, state_d;
  logic signed [DATA_WIDTH-1:0]  x_q [TAPS];
  logic signed [DATA_WIDTH-1:0]  x_d [TAPS];
  logic signed [COEFF_WIDTH-1:0] c_q [TAPS];
  logic signed [COEFF_WIDTH-1:0] c_d [TAPS];
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0]   y_out_q, y_out_d;
  logic [AW-1:0]                 idx_q, idx_d;
  logic                          y_valid_q, y_valid_d;
  logic                          coef_err_q, coef_err_d;

  logic signed [PW-1:0]          prod;
  logic signed [ACC_WIDTH-1:0]   sum;
  logic                          accept;
  logic                          addr_ok;

  assign addr_ok = 32'(bus.coef_addr) < TAPS;
  assign accept  = bus.s_valid && bus.s_ready;
  assign prod    = PW'(x_q[idx_q]) * PW'(c_q[idx_q]);
  assign sum     = acc_q + ACC_WIDTH'(prod);

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    c_d        = c_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    y_out_d    = y_out_q;
    y_valid_d  = 1'b0;
    coef_err_d = 1'b0;

    // Writes land in c_d before the MAC reads c_q, so a write on the
    // acceptance edge is already visible to that sample's sequence.
    if (bus.coef_we) begin
      if (state_q == S_IDLE && addr_ok) begin
        c_d[bus.coef_addr] = bus.coef_data;
      end else begin
        coef_err_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          x_d[0] = bus.s_data;
          for (int k = 1; k < TAPS; k++) begin
            x_d[k] = x_q[k-1];
          end
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = sum;
        idx_d = idx_q + AW'(1);
        if (idx_q == AW'(TAPS - 1)) begin
          y_out_d   = sum;
          y_valid_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      for (int k = 0; k < TAPS; k++) begin
        x_q[k] <= '0;
        c_q[k] <= '0;
      end
      acc_q      <= '0;
      idx_q      <= '0;
      y_out_q    <= '0;
      y_valid_q  <= 1'b0;
      coef_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      c_q        <= c_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      y_out_q    <= y_out_d;
      y_valid_q  <= y_valid_d;
      coef_err_q <= coef_err_d;
    end
  end

  assign bus.s_ready  = (state_q == S_IDLE) && !rst;
  assign bus.busy     = (state_q == S_MAC);
  assign bus.y_valid  = y_valid_q;
  assign bus.y_out    = y_out_q;
  assign bus.coef_err = coef_err_q;
endmodule

// File: doc/fir_mac_sequencer.md
FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, default 8, signed sample width.
- COEFF_WIDTH, default 8, signed coefficient width.
- TAPS, default 4, number of taps (2..16).
- ACC_WIDTH, default DATA_WIDTH+COEFF_WIDTH+2, signed result width.
REQ-002 Ports SHALL be:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  reset, synchronous and active-high.
- s_valid  in  1  input sample valid.
- s_ready  out  1  block can accept a sample.
- s_data  in  DATA_WIDTH  signed input sample.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  $clog2(TAPS)  coefficient index.
- coef_data  in  COEFF_WIDTH  signed coefficient value.
- coef_err  out  1  one-cycle pulse: rejected coefficient write.
- y_valid  out  1  one-cycle pulse: y_out holds a new result.
- y_out  out  ACC_WIDTH  signed filter output.
- busy  out  1  a MAC sequence is in progress.

Function
REQ-003 The block SHALL compute y = sum over k=0..TAPS-1 of c[k]*x[k] using one shared multiplier, one tap per cycle. x[0] is the newest sample.
REQ-004 FSM states SHALL be IDLE and MAC, with no other states.
REQ-005 In IDLE: s_ready=1 and busy=0. In MAC: s_ready=0 and busy=1.
REQ-006 A sample SHALL be accepted on an edge with s_valid=1 and s_ready=1.
REQ-007 On acceptance (edge E0):
- The delay line shifts: x[k]<=x[k-1], x[0]<=s_data, x[TAPS-1] is discarded.
- The accumulator clears to 0.
- The tap index is set to 0.
- The state goes to MAC.
REQ-008 In MAC, each edge SHALL add sign-extended c[idx]*x[idx] to the accumulator and increment idx. Edges E1..E_TAPS process idx 0..TAPS-1.
REQ-009 At edge E_TAPS:
- y_out loads the final sum (accumulator plus last product).
- y_valid is set to 1 for exactly one cycle.
- The state returns to IDLE.
REQ-010 Timing consequences:
- Latency from acceptance edge to y_valid high is TAPS cycles.
- Throughput is one sample per TAPS+1 cycles.
- s_ready is already 1 in the cycle where y_valid=1.
REQ-011 y_out SHALL hold its value between y_valid pulses.
REQ-012 s_valid asserted during MAC SHALL be ignored. The sample is accepted only once IDLE is reached, if the source still holds s_valid and s_data.
REQ-013 Products SHALL be signed DATA_WIDTH+COEFF_WIDTH bits, sign-extended to ACC_WIDTH. Accumulation wraps modulo 2^ACC_WIDTH; no saturation.
REQ-014 Coefficient writes SHALL be accepted only in IDLE with coef_addr < TAPS: c[coef_addr]<=coef_data at the edge.
REQ-015 A coefficient write in MAC, or with coef_addr >= TAPS, SHALL leave all coefficients unchanged and pulse coef_err high for one cycle.
REQ-016 If a coefficient write and a sample acceptance occur on the same IDLE edge, the write SHALL take effect first. The new coefficient is used by that sample's MAC sequence.

Reset
REQ-017 While rst=1 at an edge, the following SHALL be cleared:
- state to IDLE;
- all x[k] and c[k] to 0;
- accumulator, idx and y_out to 0;
- y_valid and coef_err to 0.
REQ-018 s_ready SHALL be 0 during any cycle where rst=1.
REQ-019 Reset asserted during MAC SHALL abort the sequence. No y_valid is produced for the aborted sample, and y_out reads 0 after reset.

Verification (TAPS=4, default widths)
REQ-020 Basic filtering:
- Stimulus: write c=1,2,3,4 to addr 0..3, then feed samples 1,2,3,4,5, each held until accepted.
- Required: y_out=1,4,10,20,30, each with a single y_valid pulse exactly 4 cycles after acceptance.
REQ-021 Signed extremes:
- Stimulus: c0=-128, others 0, sample -128.
- Required: y_out=16384.
- Stimulus: then sample 127.
- Required: y_out=-16256.
REQ-022 Back-pressure:
- Stimulus: hold s_valid=1 continuously with data 7.
- Required: acceptances every 5 cycles; s_ready=0 for the 4 MAC cycles; no duplicate or lost acceptance.
REQ-023 Coefficient write errors:
- Stimulus: coef_we during MAC (addr 1, data 99).
- Required: coef_err pulses once; the following result is computed with the old c1.
- Stimulus: write to addr 5 with TAPS=5.
- Required: coef_err pulses and no coefficient changes.
REQ-024 Reset mid-operation:
- Stimulus: assert rst in the 2nd MAC cycle.
- Required: no y_valid; all outputs 0; after release, sample 1 with zero coefficients gives y_out=0.
